// File: rtl/msb_arb_pkg.sv
// Shared types and default sizes for the MSB-check arbiter.
// Imported by the arbiter top and its round-robin picker.
package msb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam int N_REQ_DEF = 4;
  localparam int W_DEF     = 4;

endpackage

// File: rtl/msb_check_arbiter_rr_pick.sv
// Combinational round-robin picker: searches upward from last+1
// with wrap and reports the first requesting index.
module rr_pick
  import msb_arb_pkg::*;
#(
  parameter int N  = N_REQ_DEF,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          valid,
  output logic [IW-1:0] idx
);

  // Walk offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int i = N; i >= 1; i--) begin
      if (req[(int'(last) + i) % N]) begin
        valid = 1'b1;
        idx   = IW'((int'(last) + i) % N);
      end
    end
  end

endmodule

// File: rtl/msb_check_arbiter.sv
// Round-robin arbiter that grants one requester, captures its data
// and returns the captured slice's MSB over a valid/ready result.
module msb_check_arbiter
  import msb_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int W     = W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*W-1:0]       data,
  output logic [N_REQ-1:0]         gnt,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(N_REQ)-1:0] out_id,
  output logic                     out_msb,
  output logic                     busy
);

  localparam int IW = $clog2(N_REQ);

  state_t          state;
  logic [W-1:0]    data_q;
  logic [IW-1:0]   id_q;
  logic [IW-1:0]   last;
  logic            pick_valid;
  logic [IW-1:0]   pick_idx;
  logic [N_REQ-1:0] one;

  assign one  = {{(N_REQ-1){1'b0}}, 1'b1};
  assign busy = (state != IDLE);

  rr_pick #(
    .N  (N_REQ),
    .IW (IW)
  ) u_rr_pick (
    .req   (req),
    .last  (last),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt       <= '0;
      out_valid <= 1'b0;
      out_id    <= '0;
      out_msb   <= 1'b0;
      data_q    <= '0;
      id_q      <= '0;
      last      <= IW'(N_REQ - 1);
    end else begin
      unique case (state)
        IDLE: begin
          gnt <= '0;
          if (pick_valid) begin
            gnt    <= one << pick_idx;
            data_q <= data[pick_idx*W +: W];
            id_q   <= pick_idx;
            last   <= pick_idx;
            state  <= GRANT;
          end
        end
        GRANT: begin
          gnt       <= '0;
          out_valid <= 1'b1;
          out_id    <= id_q;
          out_msb   <= data_q[W-1];
          state     <= RESP;
        end
        RESP: begin
          gnt <= '0;
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          gnt       <= '0;
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_msb_check_arbiter.sv
// Directed plus randomized bench for msb_check_arbiter with a
// round-robin reference model kept at the transaction level.
module tb_msb_check_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [15:0] data;
  logic [3:0]  gnt;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_id;
  logic        out_msb;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int last_m = 3;

  msb_check_arbiter #(
    .N_REQ (4),
    .W     (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .data      (data),
    .gnt       (gnt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_id    (out_id),
    .out_msb   (out_msb),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_model(input logic [3:0] r);
    for (int i = 1; i <= 4; i++)
      if (r[(last_m + i) % 4]) return (last_m + i) % 4;
    return -1;
  endfunction

  task automatic txn(input logic [3:0] r, input logic [15:0] d,
                     input int dly);
    int w;
    logic [3:0] oh;
    logic msb_e;
    w = rr_model(r);
    oh = 4'(1 << w);
    msb_e = d[w*4+3];
    req = r;
    data = d;
    @(posedge clk); @(negedge clk);
    chk("gnt", gnt, oh);
    chk("busy_grant", busy, 1);
    chk("valid_grant", out_valid, 0);
    last_m = w;
    req = r & ~oh;
    data = 16'($urandom);
    out_ready = 1'($urandom_range(0, 1));
    @(posedge clk); @(negedge clk);
    chk("gnt_resp", gnt, 0);
    chk("valid", out_valid, 1);
    chk("id", out_id, w);
    chk("msb", out_msb, msb_e);
    req = r;
    for (int k = 0; k < dly; k++) begin
      out_ready = 1'b0;
      data = 16'($urandom);
      @(posedge clk); @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_id", out_id, w);
      chk("hold_msb", out_msb, msb_e);
      chk("hold_busy", busy, 1);
    end
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("done_valid", out_valid, 0);
    chk("done_busy", busy, 0);
    out_ready = 1'b0;
    req = 4'b0000;
  endtask

  initial begin
    rst_n = 1'b0;
    req = 4'b0000;
    data = 16'h0000;
    out_ready = 1'b0;
    #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_id", out_id, 0);
    chk("rst_msb", out_msb, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // single requester 0, MSB set
    txn(4'b0001, 16'h000A, 0);

    // all requesting: rotation 0,1,2,3,0 after resetting priority
    rst_n = 1'b0;
    #1;
    last_m = 3;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) txn(4'b1111, 16'($urandom), 0);

    // consumer stalls for 5 cycles
    txn(4'b0010, 16'h00F0, 5);

    // highest index, then wrap to 0
    txn(4'b1000, 16'h7000, 0);
    txn(4'b1001, 16'h8001, 1);

    // idle with out_ready high
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      chk("idle_valid", out_valid, 0);
      chk("idle_busy", busy, 0);
      chk("idle_gnt", gnt, 0);
    end
    out_ready = 1'b0;

    // reset during RESP drops the result
    req = 4'b0010;
    data = 16'hFFFF;
    @(posedge clk); @(negedge clk);
    req = 4'b0000;
    @(posedge clk); @(negedge clk);
    chk("pre_rst_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_msb", out_msb, 0);
    last_m = 3;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("post_rst_valid", out_valid, 0);
    chk("post_rst_busy", busy, 0);
    txn(4'b0100, 16'h0800, 0);

    // randomized transactions
    for (int i = 0; i < 30; i++) begin
      logic [3:0] r;
      r = 4'($urandom_range(1, 15));
      txn(r, 16'($urandom), int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
